// File: rtl/i2c_master_arbiter_pkg.sv
// rtl/i2c_master_arbiter_pkg.sv - shared types and defaults for the I2C master arbiter
// Holds the arbiter state enumeration and the default requester count, address
// width, data width and start-timeout length used by the arbiter and its bench.
package i2c_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_e;

  localparam int NUM_REQ_DEF  = 4;
  localparam int ADDR_LEN_DEF = 7;
  localparam int DATA_LEN_DEF = 8;
  localparam int START_TO_DEF = 64;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// rtl/i2c_master_arbiter_rr_pick.sv - combinational round-robin priority selector
// Ports:
//   req        in  NUM_REQ  pending requests
//   rr_ptr     in  PW       index where the priority search starts
//   win_onehot out NUM_REQ  one-hot winner (zero when nothing is pending)
//   win_idx    out PW       winner index (zero when nothing is pending)
//   win_valid  out 1        at least one request is pending
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PW-1:0]      win_idx,
  output logic               win_valid
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  logic [PW:0] idx;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = '0;
    // Walk offsets from the far end back to zero so the request closest
    // to rr_ptr (in wrap-around order) is the last one written and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) begin
        idx = idx - (PW+1)'(NUM_REQ);
      end
      if (req[idx[PW-1:0]]) begin
        win_idx   = idx[PW-1:0];
        win_valid = 1'b1;
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = win_valid;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one I2C fsm_master
// Grants the shared fsm_master to one requester at a time, launches its
// transaction, waits for the master to go busy and free again (or times out
// the start), then pulses done to the winner.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req / req_rw             per-requester request level and R_W bit
//   req_addr                 packed addresses, requester i in slice i
//   req_data1 / req_data2    packed data bytes, requester i in slice i
//   gnt                      one-hot grant held for the whole transaction
//   done / err               one-cycle completion pulse / start-timeout pulse
//   m_start .. m_data_2      drive the fsm_master start/add_reg/R_W/data inputs
//   m_free                   fsm_master free status
//   busy                     high whenever the arbiter is not idle
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int START_TO = START_TO_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data1,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data2,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic                         m_start,
  output logic [ADDR_LEN-1:0]          m_add_reg,
  output logic                         m_R_W,
  output logic [DATA_LEN-1:0]          m_data_1,
  output logic [DATA_LEN-1:0]          m_data_2,
  input  logic                         m_free,
  output logic                         busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(START_TO + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(START_TO);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         win_q, win_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  m_start_q, m_start_d;
  logic [ADDR_LEN-1:0]   m_add_q, m_add_d;
  logic                  m_rw_q, m_rw_d;
  logic [DATA_LEN-1:0]   m_d1_q, m_d1_d;
  logic [DATA_LEN-1:0]   m_d2_q, m_d2_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  to_q, to_d;

  logic [NUM_REQ-1:0]    win_onehot;
  logic [PW-1:0]         win_idx;
  logic                  win_valid;

  logic [ADDR_LEN-1:0]   sel_addr;
  logic                  sel_rw;
  logic [DATA_LEN-1:0]   sel_d1;
  logic [DATA_LEN-1:0]   sel_d2;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  // Pull the candidate winner's transaction fields out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_d1   = '0;
    sel_d2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        sel_addr = req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_rw   = req_rw[i];
        sel_d1   = req_data1[i*DATA_LEN +: DATA_LEN];
        sel_d2   = req_data2[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    m_start_d = m_start_q;
    m_add_d   = m_add_q;
    m_rw_d    = m_rw_q;
    m_d1_d    = m_d1_q;
    m_d2_d    = m_d2_q;
    cnt_d     = cnt_q;
    to_d      = to_q;

    case (state_q)
      ST_IDLE: begin
        // A busy master is never handed out, whatever req shows.
        if (m_free && win_valid) begin
          state_d   = ST_LAUNCH;
          win_d     = win_idx;
          gnt_d     = win_onehot;
          m_start_d = 1'b1;
          m_add_d   = sel_addr;
          m_rw_d    = sel_rw;
          m_d1_d    = sel_d1;
          m_d2_d    = sel_d2;
          cnt_d     = '0;
          to_d      = 1'b0;
        end
      end
      ST_LAUNCH: begin
        if (!m_free) begin
          m_start_d = 1'b0;
          state_d   = ST_WAIT_FREE;
        end else begin
          cnt_d = (cnt_q == TO_VAL) ? cnt_q : cnt_q + 1'b1;
          // The master never picked up the start: abandon and report.
          if (cnt_d >= TO_VAL) begin
            m_start_d = 1'b0;
            to_d      = 1'b1;
            state_d   = ST_DONE;
            done_d    = gnt_q;
            err_d     = 1'b1;
          end
        end
      end
      ST_WAIT_FREE: begin
        if (m_free) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
          err_d   = to_q;
        end
      end
      ST_DONE: begin
        // done/err are visible during this state; the grant is released
        // and the search restarts just past the requester just served.
        state_d  = ST_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_add_q   <= '0;
      m_rw_q    <= 1'b0;
      m_d1_q    <= '0;
      m_d2_q    <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      m_start_q <= m_start_d;
      m_add_q   <= m_add_d;
      m_rw_q    <= m_rw_d;
      m_d1_q    <= m_d1_d;
      m_d2_q    <= m_d2_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign m_start   = m_start_q;
  assign m_add_reg = m_add_q;
  assign m_R_W     = m_rw_q;
  assign m_data_1  = m_d1_q;
  assign m_data_2  = m_d2_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int A  = 7;
  localparam int D  = 8;
  localparam int TO = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*A-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [N*D-1:0] req_data1;
  logic [N*D-1:0] req_data2;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic           m_start;
  logic [A-1:0]   m_add_reg;
  logic           m_R_W;
  logic [D-1:0]   m_data_1;
  logic [D-1:0]   m_data_2;
  logic           m_free;
  logic           busy;

  i2c_master_arbiter #(
    .NUM_REQ  (N),
    .ADDR_LEN (A),
    .DATA_LEN (D),
    .START_TO (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .m_start   (m_start),
    .m_add_reg (m_add_reg),
    .m_R_W     (m_R_W),
    .m_data_1  (m_data_1),
    .m_data_2  (m_data_2),
    .m_free    (m_free),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within the cycle budget at %0t", nm, $time);
  endtask

  // Stand-in fsm_master: after seeing start for fm_fall_lat cycles it goes
  // busy for fm_hold cycles; fm_stuck keeps it free forever.
  int fm_fall_lat = 2;
  int fm_hold     = 40;
  bit fm_stuck    = 1'b0;
  int fm_phase    = 0;
  int fm_c        = 0;
  initial m_free = 1'b1;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_free   = 1'b1;
      fm_phase = 0;
      fm_c     = 0;
    end else if (fm_phase == 0) begin
      if (m_start && !fm_stuck) begin
        fm_c++;
        if (fm_c >= fm_fall_lat) begin
          m_free   = 1'b0;
          fm_phase = 1;
          fm_c     = 0;
        end
      end else begin
        fm_c = 0;
      end
    end else begin
      fm_c++;
      if (fm_c >= fm_hold) begin
        m_free   = 1'b1;
        fm_phase = 0;
        fm_c     = 0;
      end
    end
  end

  // Transaction-level reference: who should hold the grant, which phase of
  // the handshake we are in, and what was captured at grant time.
  bit         md_active, md_launch, md_wait, md_fin, md_err;
  int         md_win, md_ptr, md_lcnt;
  logic [A-1:0] cap_addr;
  logic         cap_rw;
  logic [D-1:0] cap_d1, cap_d2;

  logic           s_rst, s_free;
  logic [N-1:0]   s_req, s_rw;
  logic [N*A-1:0] s_addr;
  logic [N*D-1:0] s_d1, s_d2;
  logic [N-1:0]   exp_gnt, exp_done;

  int   st_run = 0, last_start_len = 0, done_pulses = 0, err_pulses = 0;
  bit   done_with_err = 1'b0;
  logic busy_after = 1'b1;
  int   grant_log[$];
  int   done_log[$];
  logic [N-1:0] prev_gnt = '0, prev_done = '0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    s_rst  = rst;
    s_free = m_free;
    s_req  = req;
    s_rw   = req_rw;
    s_addr = req_addr;
    s_d1   = req_data1;
    s_d2   = req_data2;

    if (s_rst) begin
      md_active = 0; md_launch = 0; md_wait = 0; md_fin = 0; md_err = 0;
      md_ptr = 0; md_win = 0; md_lcnt = 0;
      cap_addr = '0; cap_rw = 1'b0; cap_d1 = '0; cap_d2 = '0;
    end else if (md_fin) begin
      md_active = 0;
      md_fin    = 0;
      md_ptr    = (md_win + 1) % N;
    end else if (!md_active) begin
      if (s_free && s_req != '0) begin
        md_win    = pick(s_req, md_ptr);
        md_active = 1;
        md_launch = 1;
        md_lcnt   = 0;
        md_err    = 0;
        cap_addr  = s_addr[md_win*A +: A];
        cap_rw    = s_rw[md_win];
        cap_d1    = s_d1[md_win*D +: D];
        cap_d2    = s_d2[md_win*D +: D];
      end
    end else if (md_launch) begin
      if (!s_free) begin
        md_launch = 0;
        md_wait   = 1;
      end else begin
        md_lcnt++;
        if (md_lcnt == TO) begin
          md_launch = 0;
          md_fin    = 1;
          md_err    = 1;
        end
      end
    end else if (md_wait) begin
      if (s_free) begin
        md_wait = 0;
        md_fin  = 1;
      end
    end

    #1;
    exp_gnt  = '0;
    exp_done = '0;
    if (md_active) exp_gnt[md_win] = 1'b1;
    if (md_fin)    exp_done[md_win] = 1'b1;
    chk("gnt",       gnt,       exp_gnt);
    chk("done",      done,      exp_done);
    chk("err",       err,       md_fin && md_err);
    chk("m_start",   m_start,   md_launch);
    chk("busy",      busy,      md_active);
    chk("m_add_reg", m_add_reg, cap_addr);
    chk("m_R_W",     m_R_W,     cap_rw);
    chk("m_data_1",  m_data_1,  cap_d1);
    chk("m_data_2",  m_data_2,  cap_d2);

    if (m_start === 1'b1) begin
      st_run++;
    end else if (st_run != 0) begin
      last_start_len = st_run;
      st_run = 0;
    end
    if (gnt != '0 && prev_gnt == '0) grant_log.push_back(oh_idx(gnt));
    if (prev_done != '0) busy_after = busy;
    if (done != '0) begin
      done_pulses++;
      done_log.push_back(oh_idx(done));
      done_with_err = err;
    end
    if (err === 1'b1) err_pulses++;
    prev_gnt  = gnt;
    prev_done = done;
  end

  task automatic wait_done(input string nm);
    int base, k;
    base = done_pulses;
    k = 0;
    while (done_pulses == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (done_pulses == base) bound_fail(nm);
  endtask

  task automatic wait_grant(input string nm);
    int base, k;
    base = grant_log.size();
    k = 0;
    while (grant_log.size() == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (grant_log.size() == base) bound_fail(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, e0, k;
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_data1 = '0; req_data2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt",     gnt,       4'b0000);
    chk("reset_busy",    busy,      1'b0);
    chk("reset_m_start", m_start,   1'b0);
    chk("reset_m_add",   m_add_reg, 7'd0);

    // Single request
    req_addr[0 +: A]  = 7'b1010110;
    req_data1[0 +: D] = 8'hAB;
    req_data2[0 +: D] = 8'hEF;
    req_rw[0]         = 1'b1;
    d0 = done_pulses; e0 = err_pulses; g0 = grant_log.size();
    req = 4'b0001;
    wait_grant("t1_grant");
    chk("t1_gnt",   gnt,       4'b0001);
    chk("t1_addr",  m_add_reg, 7'b1010110);
    wait_done("t1_done");
    req = '0;
    repeat (3) @(negedge clk);
    chk("t1_start_len", last_start_len,     2);
    chk("t1_done_cnt",  done_pulses - d0,   1);
    chk("t1_done_idx",  done_log[d0],       0);
    chk("t1_err_cnt",   err_pulses - e0,    0);
    chk("t1_data1",     m_data_1,           8'hAB);
    chk("t1_data2",     m_data_2,           8'hEF);

    // All four at once from reset: served 0,1,2,3
    fm_hold = 3;
    do_reset();
    g0 = grant_log.size(); d0 = done_pulses;
    req = 4'b1111;
    for (int i = 0; i < N; i++) wait_done("t2_done");
    req = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (grant_log.size() > g0 + i) chk($sformatf("t2_grant_%0d", i), grant_log[g0+i], i);
      else bound_fail($sformatf("t2_grant_%0d", i));
      if (done_log.size() > d0 + i) chk($sformatf("t2_done_%0d", i), done_log[d0+i], i);
      else bound_fail($sformatf("t2_done_%0d", i));
    end

    // Fairness: req0 held, req2 raised mid-transaction
    do_reset();
    req = 4'b0001;
    wait_grant("t3_grant0");
    @(negedge clk);
    req = 4'b0101;
    wait_done("t3_done0");
    wait_grant("t3_grant1");
    chk("t3_fair", grant_log[grant_log.size()-1], 2);
    req = '0;
    wait_done("t3_done1");
    repeat (2) @(negedge clk);

    // Start timeout
    fm_stuck = 1'b1;
    e0 = err_pulses;
    req = 4'b0010;
    wait_done("t4_done");
    req = '0;
    repeat (3) @(negedge clk);
    fm_stuck = 1'b0;
    chk("t4_start_len",  last_start_len,   TO);
    chk("t4_done_err",   done_with_err,    1'b1);
    chk("t4_err_cnt",    err_pulses - e0,  1);
    chk("t4_busy_after", busy_after,       1'b0);

    // Reset while waiting for the master to free up
    fm_hold = 20;
    do_reset();
    req = 4'b0001;
    wait_done("t5_done0");
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b1111;
    wait_grant("t5_grant1");
    chk("t5_first", grant_log[grant_log.size()-1], 1);
    k = 0;
    while (!(m_free == 1'b0 && m_start == 1'b0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) bound_fail("t5_wait_free");
    d0 = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_gnt_rst",    gnt,                4'b0000);
    chk("t5_start_rst",  m_start,            1'b0);
    chk("t5_no_done",    done_pulses - d0,   0);
    wait_grant("t5_grant2");
    chk("t5_ptr_zero", grant_log[grant_log.size()-1], 0);
    req = '0;
    wait_done("t5_done2");
    repeat (2) @(negedge clk);

    // Requester withdraws five cycles after its grant
    do_reset();
    d0 = done_pulses;
    req = 4'b0010;
    wait_grant("t6_grant");
    repeat (5) @(negedge clk);
    req = '0;
    wait_done("t6_done");
    chk("t6_done_idx", done_log[done_log.size()-1], 1);
    chk("t6_done_cnt", done_pulses - d0, 1);

    // Randomized traffic, checked every cycle by the model
    for (int it = 0; it < 300; it++) begin
      req         = 4'($urandom);
      req_rw      = 4'($urandom);
      req_addr    = 28'($urandom);
      req_data1   = $urandom;
      req_data2   = $urandom;
      fm_fall_lat = $urandom_range(2, 5);
      fm_hold     = $urandom_range(1, 6);
      fm_stuck    = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 39) == 0);
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    rst = 1'b0;
    fm_stuck = 1'b0;
    req = '0;
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
